dma_line_arbiter: RTL and testbench
===================================

Name: dma_line_arbiter

Overview:
- Sequences and shares the single word-wide on-chip memory port between two line-granular DMA requesters.
- RD path: a host cache line arrives and is unpacked into memory, one word write per beat.
- WR path: the CPU requests a write-back, memory is read one word per beat, and the line is packed for the host.
- Grants whole-line bursts with round-robin fairness, generates memory addresses per requester, and emits the host FIFO pop/push pulses.
- Sits between the host DMA FIFOs and the memory-side datapath mux.

Parameters:
- CL_SIZE_WIDTH, 512, host cache-line width in bits.
- WORD_SIZE, 32, memory word width in bits. BEATS = CL_SIZE_WIDTH/WORD_SIZE (16); BEAT_BITS = $clog2(BEATS).
- RD_BASE, 32'h5000, byte base address of the RD window.
- WR_BASE, 32'h5000, byte base address of the WR window.
- WINDOW_LINES, 64, lines per window before the pointer wraps to its base (power of two).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rd_avail  in  1  host RX FIFO non-empty (!empty)
- wr_req  in  1  CPU requests a line write-back (level)
- tx_full  in  1  host TX FIFO full
- cfg_clear  in  1  one-cycle pulse: reload both pointers to their bases
- rd_grant  out  1  RD path owns the port (whole burst)
- wr_grant  out  1  WR path owns the port (whole burst)
- mem_en  out  1  memory access this cycle
- mem_wr_en  out  1  1 = write (RD burst), 0 = read (WR burst)
- mem_addr  out  32  byte address of the current beat
- beat_idx  out  BEAT_BITS  word index within the line, used by the datapath mux
- rx_pop  out  1  one-cycle pulse; maps to dma.rd_en
- tx_push  out  1  one-cycle pulse; maps to dma.wr_en
- busy  out  1  state != IDLE

Behaviour:
Reset:
- Async assert. All outputs 0; mem_addr = 0; beat_idx = 0.
- rd_ptr = RD_BASE; wr_ptr = WR_BASE; last_grant = WR (so RD wins the first tie); state = IDLE.
- Reset mid-burst aborts the burst: no pop or push is issued, and the pointers return to their bases.

States: IDLE, RD_BURST, WR_BURST, WR_COMMIT.

IDLE:
- mem_en = 0.
- Requests are sampled each cycle. Only one requester active: grant it. Both active: grant the one not in last_grant.
- Move to the burst state the next cycle; that cycle carries beat 0 (1-cycle grant latency).
- last_grant is updated on grant.

RD_BURST:
- Each cycle: mem_en = 1, mem_wr_en = 1, mem_addr = rd_ptr, beat_idx = beat counter.
- rd_ptr += WORD_SIZE/8 per beat.
- On beat BEATS-1: rx_pop = 1 in the same cycle, then return to IDLE.
- rd_avail is not re-checked mid-burst.

WR_BURST:
- Same as RD_BURST but with mem_wr_en = 0, using wr_ptr.
- After beat BEATS-1, go to WR_COMMIT.
- The datapath sees read data one cycle after each address.

WR_COMMIT:
- mem_en = 0.
- If !tx_full: tx_push = 1 for one cycle, then IDLE. Otherwise hold in WR_COMMIT indefinitely.
- wr_grant stays high through WR_COMMIT.

Grants and pulses:
- rd_grant/wr_grant are registered, mutually exclusive, and high for the entire burst.
- At least one IDLE cycle separates consecutive bursts.

Pointer wrap:
- When a pointer reaches base + WINDOW_LINES*CL_SIZE_WIDTH/8, it reloads to base on the same beat that would have produced that value.
- Arithmetic is 32-bit unsigned.

cfg_clear:
- In IDLE: both pointers reload on the next edge.
- During a burst: ignored until return to IDLE (held as a pending flag, applied on entry to IDLE).
- If cfg_clear coincides with a new grant, the clear takes effect first, so the new burst starts at base.

Optional Feature:
DMA_ARB_STATS_EN:
- When defined, adds outputs rd_line_cnt[15:0] and wr_line_cnt[15:0].
- Each increments on rx_pop / tx_push respectively and saturates at 16'hFFFF.
- Both are cleared by reset and by cfg_clear.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then rd_avail=1 only: rd_grant rises 1 cycle later. 16 beats with mem_wr_en=1 at mem_addr 0x5000..0x503C, beat_idx 0..15, rx_pop on beat 15.
- wr_req=1, tx_full=0: 16 read beats at 0x5000..0x503C with mem_wr_en=0, then tx_push 1 cycle after beat 15.
- rd_avail and wr_req held high: bursts alternate RD, WR, RD, WR. Pointers advance independently; the second RD starts at 0x5040.
- WR burst with tx_full=1 for 5 cycles after beat 15: held in WR_COMMIT with no push. tx_push fires the cycle after tx_full drops, and a pending rd_avail is granted only afterwards.
- 64 RD lines with WINDOW_LINES=64: line 63 ends at 0x5FFC, line 64 starts at 0x5000. cfg_clear mid-burst takes effect only after rx_pop.
- Assert rst_n low on beat 7 of an RD burst: outputs go to 0 immediately, no rx_pop. The next burst starts at 0x5000.

Source files
------------

// File: rtl/dma_line_arbiter.sv
// Round-robin line-burst arbiter sharing one memory word port between the host RX (RD) and TX (WR) DMA paths.
// Optional per-path line counters are enabled by defining DMA_ARB_STATS_EN.
module dma_line_arbiter #(
    parameter int          CL_SIZE_WIDTH = 512,
    parameter int          WORD_SIZE     = 32,
    parameter logic [31:0] RD_BASE       = 32'h5000,
    parameter logic [31:0] WR_BASE       = 32'h5000,
    parameter int          WINDOW_LINES  = 64,
    localparam int         BEATS         = CL_SIZE_WIDTH / WORD_SIZE,
    localparam int         BEAT_BITS     = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_avail,
    input  logic                 wr_req,
    input  logic                 tx_full,
    input  logic                 cfg_clear,
    output logic                 rd_grant,
    output logic                 wr_grant,
    output logic                 mem_en,
    output logic                 mem_wr_en,
    output logic [31:0]          mem_addr,
    output logic [BEAT_BITS-1:0] beat_idx,
    output logic                 rx_pop,
    output logic                 tx_push,
    output logic                 busy
`ifdef DMA_ARB_STATS_EN
    ,
    output logic [15:0]          rd_line_cnt,
    output logic [15:0]          wr_line_cnt
`endif
);

    localparam logic [31:0]          STEP      = 32'(WORD_SIZE / 8);
    localparam logic [31:0]          WIN_BYTES = 32'(WINDOW_LINES * CL_SIZE_WIDTH / 8);
    localparam logic [31:0]          RD_END    = RD_BASE + WIN_BYTES;
    localparam logic [31:0]          WR_END    = WR_BASE + WIN_BYTES;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, WR_COMMIT} state_t;

    state_t               state_reg, state_next;
    logic [BEAT_BITS-1:0] beat_reg;
    logic [31:0]          rd_ptr_reg, wr_ptr_reg;
    logic                 last_wr_reg;
    logic                 clr_pend_reg;
    logic                 rd_grant_reg, wr_grant_reg;
    logic                 last_beat;
    logic [31:0]          rd_sum, wr_sum, rd_ptr_next, wr_ptr_next;

    assign last_beat = (beat_reg == LAST_BEAT);
    assign rd_sum    = rd_ptr_reg + STEP;
    assign wr_sum    = wr_ptr_reg + STEP;
    // Wrap on the beat that would land exactly on the window end.
    assign rd_ptr_next = (rd_sum == RD_END) ? RD_BASE : rd_sum;
    assign wr_ptr_next = (wr_sum == WR_END) ? WR_BASE : wr_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rd_grant_reg <= 1'b0;
            wr_grant_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_grant_reg <= (state_next == RD_BURST);
            wr_grant_reg <= (state_next == WR_BURST) || (state_next == WR_COMMIT);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // Tie goes to whichever path did not win last time.
                if (rd_avail && (!wr_req || last_wr_reg))
                    state_next = RD_BURST;
                else if (wr_req)
                    state_next = WR_BURST;
            end
            RD_BURST:  if (last_beat) state_next = IDLE;
            WR_BURST:  if (last_beat) state_next = WR_COMMIT;
            WR_COMMIT: if (!tx_full)  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 32'd0;
        beat_idx  = '0;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            RD_BURST: begin
                mem_en    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = rd_ptr_reg;
                beat_idx  = beat_reg;
                rx_pop    = last_beat;
                busy      = 1'b1;
            end
            WR_BURST: begin
                mem_en   = 1'b1;
                mem_addr = wr_ptr_reg;
                beat_idx = beat_reg;
                busy     = 1'b1;
            end
            WR_COMMIT: begin
                tx_push = !tx_full;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_grant = rd_grant_reg;
    assign wr_grant = wr_grant_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg     <= '0;
            rd_ptr_reg   <= RD_BASE;
            wr_ptr_reg   <= WR_BASE;
            last_wr_reg  <= 1'b1;
            clr_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    beat_reg <= '0;
                    // A clear lands before any grant issued in this same cycle.
                    if (cfg_clear || clr_pend_reg) begin
                        rd_ptr_reg <= RD_BASE;
                        wr_ptr_reg <= WR_BASE;
                    end
                    clr_pend_reg <= 1'b0;
                    if (state_next == RD_BURST) last_wr_reg <= 1'b0;
                    if (state_next == WR_BURST) last_wr_reg <= 1'b1;
                end
                RD_BURST: begin
                    beat_reg   <= last_beat ? '0 : beat_reg + BEAT_BITS'(1);
                    rd_ptr_reg <= rd_ptr_next;
                    if (cfg_clear) clr_pend_reg <= 1'b1;
                end
                WR_BURST: begin
                    beat_reg   <= last_beat ? '0 : beat_reg + BEAT_BITS'(1);
                    wr_ptr_reg <= wr_ptr_next;
                    if (cfg_clear) clr_pend_reg <= 1'b1;
                end
                default: begin
                    if (cfg_clear) clr_pend_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMA_ARB_STATS_EN
    logic [1:0]  line_evt;
    logic [15:0] line_cnt_reg [2];

    assign line_evt = {tx_push, rx_pop};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    line_cnt_reg[gi] <= 16'd0;
                else if (cfg_clear)
                    line_cnt_reg[gi] <= 16'd0;
                else if (line_evt[gi] && (line_cnt_reg[gi] != 16'hFFFF))
                    line_cnt_reg[gi] <= line_cnt_reg[gi] + 16'd1;
            end
        end
    endgenerate

    assign rd_line_cnt = line_cnt_reg[0];
    assign wr_line_cnt = line_cnt_reg[1];
`endif

endmodule

// File: tb/tb_dma_line_arbiter.sv
// Directed bench for dma_line_arbiter: single bursts, alternation, commit stall, pointer wrap, cfg_clear and mid-burst reset.
module tb_dma_line_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rd_avail, wr_req, tx_full, cfg_clear;
    logic        rd_grant, wr_grant, mem_en, mem_wr_en, rx_pop, tx_push, busy;
    logic [31:0] mem_addr;
    logic [3:0]  beat_idx;
`ifdef DMA_ARB_STATS_EN
    logic [15:0] rd_line_cnt, wr_line_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dma_line_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_avail  (rd_avail),
        .wr_req    (wr_req),
        .tx_full   (tx_full),
        .cfg_clear (cfg_clear),
        .rd_grant  (rd_grant),
        .wr_grant  (wr_grant),
        .mem_en    (mem_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .beat_idx  (beat_idx),
        .rx_pop    (rx_pop),
        .tx_push   (tx_push),
        .busy      (busy)
`ifdef DMA_ARB_STATS_EN
        ,
        .rd_line_cnt (rd_line_cnt),
        .wr_line_cnt (wr_line_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge in IDLE with rd_avail already high.
    task automatic do_rd_line(input logic [31:0] start, input bit keep, input bit clr_idle, input int clr_beat);
        chk("rd idle busy", busy, 0);
        chk("rd idle grant", rd_grant, 0);
        chk("rd idle mem_en", mem_en, 0);
        if (clr_idle) cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        rd_avail  = keep;
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("rd grant b%0d", b), rd_grant, 1);
            chk($sformatf("rd wgrant b%0d", b), wr_grant, 0);
            chk($sformatf("rd mem_en b%0d", b), mem_en, 1);
            chk($sformatf("rd wr_en b%0d", b), mem_wr_en, 1);
            chk($sformatf("rd addr b%0d", b), mem_addr, start + 32'(4 * b));
            chk($sformatf("rd beat b%0d", b), beat_idx, 32'(b));
            chk($sformatf("rd pop b%0d", b), rx_pop, (b == 15) ? 1 : 0);
            if (b == clr_beat) cfg_clear = 1'b1;
            step();
            cfg_clear = 1'b0;
        end
        chk("rd end grant", rd_grant, 0);
        chk("rd end busy", busy, 0);
        chk("rd end pop", rx_pop, 0);
        $display("RD line start=%h done (cmp=%0d bad=%0d)", start, n_cmp, n_bad);
    endtask

    // Entered at a negedge in IDLE with wr_req high; tx_full is held for 'hold' commit cycles.
    task automatic do_wr_line(input logic [31:0] start, input bit keep, input int hold);
        chk("wr idle busy", busy, 0);
        chk("wr idle grant", wr_grant, 0);
        step();
        wr_req = keep;
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("wr grant b%0d", b), wr_grant, 1);
            chk($sformatf("wr rgrant b%0d", b), rd_grant, 0);
            chk($sformatf("wr mem_en b%0d", b), mem_en, 1);
            chk($sformatf("wr wr_en b%0d", b), mem_wr_en, 0);
            chk($sformatf("wr addr b%0d", b), mem_addr, start + 32'(4 * b));
            chk($sformatf("wr beat b%0d", b), beat_idx, 32'(b));
            chk($sformatf("wr push b%0d", b), tx_push, 0);
            step();
        end
        for (int k = 0; k < hold; k++) begin
            chk($sformatf("commit hold push c%0d", k), tx_push, 0);
            chk($sformatf("commit hold grant c%0d", k), wr_grant, 1);
            chk($sformatf("commit hold rgrant c%0d", k), rd_grant, 0);
            chk($sformatf("commit hold mem_en c%0d", k), mem_en, 0);
            chk($sformatf("commit hold busy c%0d", k), busy, 1);
            step();
        end
        tx_full = 1'b0;
        #1;
        chk("commit push", tx_push, 1);
        chk("commit grant", wr_grant, 1);
        chk("commit mem_en", mem_en, 0);
        step();
        chk("wr end grant", wr_grant, 0);
        chk("wr end push", tx_push, 0);
        chk("wr end busy", busy, 0);
        $display("WR line start=%h hold=%0d done (cmp=%0d bad=%0d)", start, hold, n_cmp, n_bad);
    endtask

    initial begin
        rst_n = 1'b0; rd_avail = 1'b0; wr_req = 1'b0; tx_full = 1'b0; cfg_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset grants", {rd_grant, wr_grant}, 0);
        chk("reset mem_en", mem_en, 0);
        chk("reset addr", mem_addr, 0);
        chk("reset beat", beat_idx, 0);
        chk("reset pulses", {rx_pop, tx_push}, 0);
        rst_n = 1'b1;
        step();
        chk("idle after reset busy", busy, 0);

        // Single RD line, then a single WR line.
        rd_avail = 1'b1;
        do_rd_line(32'h5000, 1'b0, 1'b0, -1);
        wr_req = 1'b1;
        do_wr_line(32'h5000, 1'b0, 0);

        // Both requesting: strict alternation, independent pointers.
        rd_avail = 1'b1; wr_req = 1'b1;
        do_rd_line(32'h5040, 1'b1, 1'b0, -1);
        do_wr_line(32'h5040, 1'b1, 0);
        do_rd_line(32'h5080, 1'b1, 1'b0, -1);
        do_wr_line(32'h5080, 1'b0, 0);
        do_rd_line(32'h50C0, 1'b0, 1'b0, -1);

        // WR wins the tie (RD went last); commit stalls on tx_full while RD waits.
        rd_avail = 1'b1; wr_req = 1'b1; tx_full = 1'b1;
        do_wr_line(32'h50C0, 1'b0, 5);
        do_rd_line(32'h5100, 1'b0, 1'b0, -1);

        // Clear coinciding with a grant, then full window wrap of the RD pointer.
        rd_avail = 1'b1;
        for (int i = 0; i < 64; i++)
            do_rd_line(32'h5000 + 32'(64 * i), 1'b1, (i == 0), -1);
        do_rd_line(32'h5000, 1'b1, 1'b0, 7);
        do_rd_line(32'h5000, 1'b0, 1'b0, -1);
        wr_req = 1'b1;
        do_wr_line(32'h5000, 1'b0, 0);

        // Reset asserted on beat 7 of an RD burst.
        rd_avail = 1'b1;
        step();
        for (int b = 0; b < 7; b++) begin
            chk($sformatf("pre-reset addr b%0d", b), mem_addr, 32'h5040 + 32'(4 * b));
            step();
        end
        chk("beat7 addr", mem_addr, 32'h505C);
        chk("beat7 beat", beat_idx, 7);
        rst_n = 1'b0;
        #1;
        chk("midreset grant", rd_grant, 0);
        chk("midreset mem_en", mem_en, 0);
        chk("midreset addr", mem_addr, 0);
        chk("midreset beat", beat_idx, 0);
        chk("midreset busy", busy, 0);
        chk("midreset pop", rx_pop, 0);
        step();
        chk("in reset pop", rx_pop, 0);
        rst_n = 1'b1;
        do_rd_line(32'h5000, 1'b0, 1'b0, -1);
        wr_req = 1'b1;
        do_wr_line(32'h5000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
